// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared definitions for the two-master Wishbone arbiter.
//   - arb_state_t : arbiter FSM states
//   - CTI_*       : Wishbone cycle type identifiers
//   - GNT_*       : one-hot grant encodings ({m1,m0})
//   - gnt_other() : the grant of the master that is not currently granted
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ERR   = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Swapping the two one-hot bits hands the bus to the other master.
  function automatic logic [1:0] gnt_other(input logic [1:0] gnt);
    return {gnt[0], gnt[1]};
  endfunction

endpackage

// File: rtl/wb_bus_timeout.sv
// wb_bus_timeout: slave-response watchdog counter.
//   clk     : system clock (rising edge)
//   rst     : asynchronous active-high reset, clears the counter
//   clr     : clear the counter this cycle (has priority over inc)
//   inc     : one stalled slave cycle; counter saturates at TIMEOUT
//   expired : this cycle's increment brings the counter to TIMEOUT
// TIMEOUT = 0 removes the counter entirely; expired is then constant 0.
module wb_bus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clr, inc};
      assign expired       = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

      logic [CW-1:0] count_reg;
      logic [CW-1:0] count_next;

      always_comb begin
        count_next = count_reg;
        if (clr) begin
          count_next = '0;
        end else if (inc && (count_reg != LIMIT)) begin
          count_next = count_reg + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_reg <= '0;
        end else begin
          count_reg <= count_next;
        end
      end

      // Flag the edge on which the counter lands on TIMEOUT so the arbiter
      // leaves BUSY on that same edge. A response in this cycle sets clr,
      // so a late ack still beats the watchdog.
      assign expired = !clr && inc && (count_next == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master / one-slave Wishbone B3 arbiter.
// Round-robin grant on ties, the owner keeps the bus for its whole cyc_i
// (bursts and RMW never split), and a watchdog aborts a stalled slave cycle.
// Ports:
//   clk_i, rst_i               : clock, asynchronous active-high reset
//   m0_*_i / m1_*_i            : master request (adr, dat, sel, we, cti, bte, cyc, stb)
//   m0_/m1_dat_o               : read data, s_dat_i broadcast to both masters
//   m0_/m1_ ack/err/rty_o      : slave response, delivered to the owner only
//   s_*_o                      : slave request, the owner's request while granted
//   s_dat_i, s_ack/err/rty_i   : slave response
//   grant_o                    : one-hot owner {m1,m0}, 00 when nobody owns
//   timeout_o                  : one-cycle pulse in the watchdog abort cycle
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  arb_state_t state_reg, state_next;
  logic [1:0] grant_reg, grant_next;
  logic       last_m1_reg, last_m1_next;  // 1: m1 owned the bus last

  logic own_cyc;
  logic own_stb;
  logic other_cyc;
  logic s_resp;
  logic in_busy;
  logic in_err;
  logic wd_inc;
  logic wd_clr;
  logic wd_expired;

  assign in_busy = (state_reg == ST_BUSY);
  assign in_err  = (state_reg == ST_ERR);
  assign s_resp  = s_ack_i | s_err_i | s_rty_i;

  // Owner / other-master views of the request lines.
  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    other_cyc = 1'b0;
    if (grant_reg[1]) begin
      own_cyc   = m1_cyc_i;
      own_stb   = m1_stb_i;
      other_cyc = m0_cyc_i;
    end else if (grant_reg[0]) begin
      own_cyc   = m0_cyc_i;
      own_stb   = m0_stb_i;
      other_cyc = m1_cyc_i;
    end
  end

  // A stalled cycle is a strobed BUSY cycle with no response. Anything else
  // (idle, stb low, response, handover or abort) restarts the count.
  assign wd_inc = in_busy && s_stb_o && !s_resp;
  assign wd_clr = !wd_inc;

  wb_bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk_i),
    .rst     (rst_i),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  // Next-state, grant and round-robin history.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    last_m1_next = last_m1_reg;
    case (state_reg)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          grant_next = last_m1_reg ? GNT_M0 : GNT_M1;
          state_next = ST_BUSY;
        end else if (m0_cyc_i) begin
          grant_next = GNT_M0;
          state_next = ST_BUSY;
        end else if (m1_cyc_i) begin
          grant_next = GNT_M1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!own_cyc) begin
          last_m1_next = grant_reg[1];
          if (other_cyc) begin
            // Direct handover: the waiting master gets the bus with no idle gap.
            grant_next = gnt_other(grant_reg);
          end else begin
            grant_next = GNT_NONE;
            state_next = ST_IDLE;
          end
        end else if (wd_expired) begin
          state_next = ST_ERR;
        end
      end
      ST_ERR: begin
        state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!own_cyc) begin
          last_m1_next = grant_reg[1];
          grant_next   = GNT_NONE;
          state_next   = ST_IDLE;
        end
      end
      default: begin
        grant_next = GNT_NONE;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= GNT_NONE;
      last_m1_reg <= 1'b1;  // m0 wins the first tie after reset
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      last_m1_reg <= last_m1_next;
    end
  end

  // Request routing: owner's request to the slave. cyc/stb only reach the
  // slave in BUSY, so ERR and DRAIN cut the aborted master off immediately.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = CTI_CLASSIC;
    s_bte_o = 2'b00;
    if (grant_reg[1]) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cti_o = m1_cti_i;
      s_bte_o = m1_bte_i;
    end else if (grant_reg[0]) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
    end
  end

  // stb is qualified with cyc so a master dropping cyc also drops stb.
  assign s_cyc_o = in_busy && own_cyc;
  assign s_stb_o = s_cyc_o && own_stb;

  // Response routing: combinational from the slave, owner only.
  assign m0_ack_o = in_busy && grant_reg[0] && s_ack_i;
  assign m0_rty_o = in_busy && grant_reg[0] && s_rty_i;
  assign m0_err_o = grant_reg[0] && ((in_busy && s_err_i) || in_err);
  assign m1_ack_o = in_busy && grant_reg[1] && s_ack_i;
  assign m1_rty_o = in_busy && grant_reg[1] && s_rty_i;
  assign m1_err_o = grant_reg[1] && ((in_busy && s_err_i) || in_err);

  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign grant_o   = grant_reg;
  assign timeout_o = in_err;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
module tb_wb_arbiter_2m;
  import wb_arb_pkg::*;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  logic [3:0]  sel [2];
  logic        we  [2];
  logic [2:0]  cti [2];
  logic [1:0]  bte [2];
  logic        cyc [2];
  logic        stb [2];

  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic        s_cyc_o, s_stb_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_sel_i(sel[0]), .m0_we_i(we[0]),
    .m0_cti_i(cti[0]), .m0_bte_i(bte[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_sel_i(sel[1]), .m1_we_i(we[1]),
    .m1_cti_i(cti[1]), .m1_bte_i(bte[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // owner: -1 none, 0 m0, 1 m1.  phase: 0 idle, 1 owned, 2 abort, 3 drain.
  int mo_owner;
  int mo_phase;
  int mo_last;
  int mo_stall;

  task automatic model_step();
    case (mo_phase)
      0: begin
        if (cyc[0] && cyc[1]) mo_owner = (mo_last == 0) ? 1 : 0;
        else if (cyc[0])      mo_owner = 0;
        else if (cyc[1])      mo_owner = 1;
        if (mo_owner >= 0) begin
          mo_phase = 1;
          mo_stall = 0;
        end
      end
      1: begin
        if (!cyc[mo_owner]) begin
          mo_last  = mo_owner;
          mo_stall = 0;
          if (cyc[1 - mo_owner]) mo_owner = 1 - mo_owner;
          else begin
            mo_owner = -1;
            mo_phase = 0;
          end
        end else if (stb[mo_owner] && !(s_ack_i || s_err_i || s_rty_i)) begin
          mo_stall++;
          if (mo_stall == TO) begin
            mo_phase = 2;
            mo_stall = 0;
          end
        end else begin
          mo_stall = 0;
        end
      end
      2: mo_phase = 3;
      default: begin
        if (!cyc[mo_owner]) begin
          mo_last  = mo_owner;
          mo_owner = -1;
          mo_phase = 0;
        end
      end
    endcase
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mo_owner = -1;
      mo_phase = 0;
      mo_last  = 1;
      mo_stall = 0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin : cmp
    logic [1:0] e_gnt;
    logic       e_cyc, e_stb;
    logic [2:0] e_r0, e_r1;
    logic [2:0] slave_r;
    e_gnt   = (mo_owner < 0) ? 2'b00 : (mo_owner == 0 ? 2'b01 : 2'b10);
    e_cyc   = (mo_phase == 1) && (mo_owner >= 0) && cyc[mo_owner];
    e_stb   = e_cyc && stb[mo_owner];
    slave_r = {s_ack_i, s_err_i, s_rty_i};
    e_r0 = 3'b000;
    e_r1 = 3'b000;
    if (mo_phase == 1 && mo_owner == 0) e_r0 = slave_r;
    if (mo_phase == 1 && mo_owner == 1) e_r1 = slave_r;
    if (mo_phase == 2 && mo_owner == 0) e_r0 = 3'b010;
    if (mo_phase == 2 && mo_owner == 1) e_r1 = 3'b010;
    chk("m_grant", grant_o, e_gnt);
    chk("m_cyc_stb", {s_cyc_o, s_stb_o}, {e_cyc, e_stb});
    chk("m_resp0", {m0_ack_o, m0_err_o, m0_rty_o}, e_r0);
    chk("m_resp1", {m1_ack_o, m1_err_o, m1_rty_o}, e_r1);
    chk("m_timeout", timeout_o, (mo_phase == 2));
    chk("m_dat_o", {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
    if (e_cyc) begin
      chk("m_req_adr", s_adr_o, adr[mo_owner]);
      chk("m_req_misc", {s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o},
          {dat[mo_owner], sel[mo_owner], we[mo_owner], cti[mo_owner], bte[mo_owner]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_masters();
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0;
      stb[i] = 1'b0;
    end
  endtask

  initial begin
    int dead;
    int blk;
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      adr[i] = 32'h0; dat[i] = 32'h0; sel[i] = 4'hF; we[i] = 1'b0;
      cti[i] = CTI_CLASSIC; bte[i] = 2'b00; cyc[i] = 1'b0; stb[i] = 1'b0;
    end
    s_dat_i = 32'h0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_scyc", {s_cyc_o, s_stb_o}, 2'b00);
    chk("rst_timeout", timeout_o, 1'b0);
    rst_i = 1'b0;

    // Tie after reset: m0 first, then handover to waiting m1 with no gap.
    tick();
    cyc[0] = 1; stb[0] = 1; adr[0] = 32'h100;
    cyc[1] = 1; stb[1] = 1; adr[1] = 32'h200;
    #1 chk("tie_pre_scyc", s_cyc_o, 1'b0);
    tick();
    #1 chk("tie_grant", grant_o, 2'b01);
    chk("tie_adr", s_adr_o, 32'h100);
    cyc[0] = 0; stb[0] = 0;
    #1 chk("release_scyc", s_cyc_o, 1'b0);
    tick();
    #1 chk("handover_grant", grant_o, 2'b10);
    chk("handover_scyc", s_cyc_o, 1'b1);
    chk("handover_adr", s_adr_o, 32'h200);
    idle_masters();
    tick();
    #1 chk("idle_grant", grant_o, 2'b00);

    // Single master read of 0x100 with a 1-cycle slave.
    cyc[0] = 1; stb[0] = 1; adr[0] = 32'h100;
    #1 chk("single_latency", s_cyc_o, 1'b0);
    tick();
    #1 chk("single_grant", grant_o, 2'b01);
    s_ack_i = 1; s_dat_i = 32'hCAFE0001;
    #1 chk("single_ack", {m0_ack_o, m1_ack_o, m1_err_o, m1_rty_o}, 4'b1000);
    chk("single_dat", m0_dat_o, 32'hCAFE0001);
    tick();
    s_ack_i = 0; idle_masters();
    tick();

    // Burst lock: m1 INCR burst holds the bus while m0 waits.
    cyc[1] = 1; stb[1] = 1; cti[1] = CTI_INCR;
    tick();
    cyc[0] = 1; stb[0] = 1; s_ack_i = 1;
    for (int b = 0; b < 4; b++) begin
      cti[1] = (b == 3) ? CTI_EOB : CTI_INCR;
      adr[1] = 32'h200 + 32'(4 * b);
      #1;
      chk("burst_grant", grant_o, 2'b10);
      chk("burst_acks", {m1_ack_o, m0_ack_o}, 2'b10);
      chk("burst_cti", s_cti_o, (b == 3) ? 3'b111 : 3'b010);
      tick();
    end
    cyc[1] = 0; stb[1] = 0; s_ack_i = 0; cti[1] = CTI_CLASSIC;
    tick();
    #1 chk("burst_then_m0", grant_o, 2'b01);
    idle_masters();
    tick();

    // Watchdog: slave never answers m0.
    cyc[0] = 1; stb[0] = 1;
    tick();
    for (int i = 0; i < TO; i++) begin
      #1 chk("wd_stall_no_to", {timeout_o, s_cyc_o}, 2'b01);
      tick();
    end
    #1 chk("wd_err_cycle", {timeout_o, m0_err_o, s_cyc_o, m1_err_o}, 4'b1100);
    tick();
    #1 chk("wd_drain", {timeout_o, m0_err_o, s_cyc_o, grant_o}, 5'b00001);
    tick();
    #1 chk("wd_drain_hold", grant_o, 2'b01);
    idle_masters();
    tick();
    #1 chk("wd_idle", grant_o, 2'b00);

    // A response on the last stalled cycle beats the watchdog.
    cyc[0] = 1; stb[0] = 1;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    s_ack_i = 1;
    #1 chk("late_ack", {m0_ack_o, timeout_o}, 2'b10);
    tick();
    s_ack_i = 0;
    #1 chk("late_ack_after", {timeout_o, m0_err_o, s_cyc_o}, 3'b001);
    idle_masters();
    tick();

    // Asynchronous reset in the middle of an m1 burst.
    cyc[1] = 1; stb[1] = 1; cti[1] = CTI_INCR;
    tick();
    s_ack_i = 1;
    tick();
    cyc[0] = 1; stb[0] = 1;
    #1 rst_i = 1;
    #1 chk("arst_outputs", {s_cyc_o, grant_o, m1_ack_o, m0_ack_o}, 5'b0);
    tick();
    rst_i = 0; s_ack_i = 0;
    tick();
    #1 chk("arst_tie_m0", grant_o, 2'b01);
    idle_masters(); cti[1] = CTI_CLASSIC;
    tick();

    // Randomized traffic checked every cycle by the model comparison.
    dead = 0;
    blk  = 0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (blk == 0) begin
        dead = ($urandom_range(0, 2) == 0) ? 1 : 0;
        blk  = 40;
      end
      blk--;
      rst_i = rst_i ? 1'b0 : ($urandom_range(0, 599) == 0);
      for (int i = 0; i < 2; i++) begin
        if (cyc[i]) begin
          if ($urandom_range(0, dead ? 39 : 5) == 0) cyc[i] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          cyc[i] = 1;
        end
        stb[i] = cyc[i] && ($urandom_range(0, 3) != 0);
        adr[i] = $urandom;
        dat[i] = $urandom;
        sel[i] = 4'($urandom);
        we[i]  = 1'($urandom);
        cti[i] = 3'($urandom);
        bte[i] = 2'($urandom);
      end
      s_dat_i = $urandom;
      s_ack_i = !dead && ($urandom_range(0, 2) == 0);
      s_err_i = !dead && ($urandom_range(0, 15) == 0);
      s_rty_i = !dead && ($urandom_range(0, 15) == 0);
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master, one-slave Wishbone B3 arbiter with round-robin grant, whole-cycle bus locking and a slave-response watchdog. It shares a single slave port (the system SRAM) between the CPU instruction master (m0) and data master (m1). It sits between the CPU wrapper's iwbm/dwbm ports and the RAM's wb_* slave port, in front of the bus matrix.

## Interface
- AW, 32, address width
- DW, 32, data width; select width is DW/8
- TIMEOUT, 255, slave cycles without ack/err/rty before the watchdog fires; 0 disables the watchdog
- clk_i  input  1  system clock; all logic is rising-edge
- rst_i  input  1  asynchronous, active-high reset
- m0_/m1_ adr_i, dat_i, sel_i, we_i, cti_i, bte_i, cyc_i, stb_i  input  AW/DW/DW/8/1/3/2/1/1  master requests
- m0_/m1_ dat_o  output  DW  read data; carries s_dat_i to both masters unconditionally
- m0_/m1_ ack_o, err_o, rty_o  output  1 each  slave response, owner only
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o  output  AW/DW/DW/8/1/3/2/1/1  slave request
- s_dat_i, s_ack_i, s_err_i, s_rty_i  input  DW/1/1/1  slave response
- grant_o  output  2  one-hot owner ({m1,m0}); 2'b00 = no owner
- timeout_o  output  1  one-cycle pulse when the watchdog fires

## Operation
- Reset values: grant_o=00, all s_* request outputs 0, all master ack/err/rty 0, timeout_o=0, watchdog counter 0, state IDLE, last_owner=m1 (so m0 wins the first tie).
- FSM states: IDLE, BUSY, ERR, DRAIN.
- IDLE, neither cyc_i high: stay in IDLE.
- IDLE, one cyc_i high: grant that master, go to BUSY.
- IDLE, both cyc_i high: grant the master that is not last_owner, go to BUSY.
- BUSY, owner cyc_i high: hold the grant (bus lock). Bursts (cti 001/010) and RMW sequences are never split.
- BUSY, owner cyc_i low:
  - other master's cyc_i high: grant it directly and stay in BUSY.
  - otherwise: go to IDLE.
  - In both cases last_owner takes the old owner.
- Routing while granted:
  - s_* request outputs carry the owner's inputs, with s_cyc_o = owner cyc_i and s_stb_o = owner stb_i.
  - Owner ack/err/rty = s_ack_i/s_err_i/s_rty_i.
  - Non-owner ack/err/rty are held 0.
  - With no owner, s_cyc_o = s_stb_o = 0.
- Watchdog:
  - Counter increments each BUSY cycle with s_stb_o=1 and no s_ack_i, s_err_i or s_rty_i.
  - Counter clears on any slave response, on stb low, and on a grant change.
  - Counter saturates at TIMEOUT.
  - Counter == TIMEOUT while in BUSY: go to ERR.
- ERR (exactly 1 cycle):
  - s_cyc_o = s_stb_o = 0.
  - Owner err_o = 1; timeout_o = 1.
  - Then go to DRAIN.
- DRAIN:
  - s_cyc_o = s_stb_o = 0; master responses are 0.
  - Wait for the owner's cyc_i to go low, then go to IDLE with last_owner = owner.
  - The owner never reaches the slave again in the same cycle.
- Counter width: $clog2(TIMEOUT+1). TIMEOUT=0 disables the watchdog: the counter is held at 0 and ERR is unreachable.

## Timing
- Grant is registered. A request seen in IDLE at edge N appears on s_cyc_o after edge N (one cycle of arbitration latency).
- Response path s_ack_i -> owner ack_o is combinational (zero latency). The arbiter adds no wait states after the grant.
- Owner drops cyc_i in cycle N: s_cyc_o falls combinationally in cycle N.
- Back-to-back handover: if the other master is waiting, its s_cyc_o rises after edge N (no idle gap).
- Simultaneous events:
  - Owner releases and the other master requests in the same cycle: handover to the other master.
  - Slave response in the same cycle the counter would reach TIMEOUT: the response wins and the counter clears.
- Reset mid-cycle: all outputs clear asynchronously on rst_i rise. The slave sees its cycle aborted. The FSM resumes from IDLE after rst_i falls.

## Structure
- Package wb_arb_pkg holds:
  - the state encoding enum (IDLE, BUSY, ERR, DRAIN);
  - CTI constants: CLASSIC=000, CONST=001, INCR=010, EOB=111;
  - the grant encodings.
- Sub-module wb_bus_timeout (parameter TIMEOUT; inputs clr, inc; output expired) holds the watchdog counter.
- FSM, grant register and routing muxes stay in wb_arbiter_2m.

## Test plan
- Single master: m0 reads 0x100 against a slave acking in 1 cycle -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o pulses; grant_o=01; m1 responses stay 0.
- Tie after reset: m0 and m1 assert cyc_i on the same edge -> grant_o=01 first. After m0 drops with m1 still requesting -> grant_o=10 on the next cycle with no idle gap.
- Burst lock: m1 INCR 4-beat burst (cti 010,010,010,111) while m0 requests -> all 4 beats complete under grant_o=10 before m0 is granted.
- Watchdog: TIMEOUT=8, slave never acks -> after 8 stalled cycles: ERR cycle with m0_err_o=1, timeout_o=1, s_cyc_o=0. DRAIN holds until m0 drops cyc_i, then IDLE.
- Response beats timeout: TIMEOUT=8, s_ack_i arrives on the 8th stalled cycle -> ack delivered, no err_o, no timeout_o.
- Async reset mid-burst: rst_i rises during beat 2 -> s_cyc_o, grant_o and ack outputs go 0 immediately. After release, m0 wins the next tie.
